// File: rtl/seq_add_sub_if.sv
// Handshake and data bundle for the sequential adder/subtractor.
interface seq_add_sub_if #(
  parameter int unsigned WIDTH = 32
);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             sna;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] y;
  logic             co;
  logic             ovf;
  logic             zf;

  modport master (
    output start, a, b, sna,
    input  busy, done, y, co, ovf, zf
  );

  modport slave (
    input  start, a, b, sna,
    output busy, done, y, co, ovf, zf
  );
endinterface

// File: rtl/seq_add_sub.sv
// Multi-cycle ripple-carry add/subtract: SLICE bits per clock, carry registered between slices,
// with carry, signed-overflow and zero flags committed only when the last slice completes.
module seq_add_sub #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned SLICE = 8
) (
  input logic          clk,
  input logic          rst,
  seq_add_sub_if.slave bus
);
  localparam int unsigned N    = WIDTH / SLICE;
  localparam int unsigned CntW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [0:0] {StIdle, StRun} state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d, part_q, part_d, y_q, y_d;
  logic             sna_q, sna_d, carry_q, carry_d;
  logic             co_q, co_d, ovf_q, ovf_d, zf_q, zf_d, done_q, done_d;
  logic [CntW-1:0]  cnt_q, cnt_d;

  logic [WIDTH-1:0] a_shr, b_shr, part_nxt;
  logic [SLICE-1:0] b_x;
  logic [SLICE:0]   sum;
  logic             c_msb;
  logic             last;

  // Operands shift down one slice per cycle so the active slice is always the low SLICE bits;
  // sum bits enter the partial result from the top, leaving it aligned after N slices.
  if (N > 1) begin : g_shift
    assign a_shr    = {{SLICE{1'b0}}, a_q[WIDTH-1:SLICE]};
    assign b_shr    = {{SLICE{1'b0}}, b_q[WIDTH-1:SLICE]};
    assign part_nxt = {sum[SLICE-1:0], part_q[WIDTH-1:SLICE]};
  end else begin : g_single
    assign a_shr    = a_q;
    assign b_shr    = b_q;
    assign part_nxt = sum[SLICE-1:0];
  end

  assign b_x   = b_q[SLICE-1:0] ^ {SLICE{sna_q}};
  assign sum   = {1'b0, a_q[SLICE-1:0]} + {1'b0, b_x} + {{SLICE{1'b0}}, carry_q};
  // Carry into the slice MSB recovered from its sum bit; on the last slice this is bit WIDTH-1.
  assign c_msb = a_q[SLICE-1] ^ b_x[SLICE-1] ^ sum[SLICE-1];
  assign last  = (cnt_q == CntW'(N - 1));

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    sna_d   = sna_q;
    carry_d = carry_q;
    cnt_d   = cnt_q;
    part_d  = part_q;
    y_d     = y_q;
    co_d    = co_q;
    ovf_d   = ovf_q;
    zf_d    = zf_q;
    done_d  = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (bus.start) begin
          a_d     = bus.a;
          b_d     = bus.b;
          sna_d   = bus.sna;
          carry_d = bus.sna;
          cnt_d   = '0;
          state_d = StRun;
        end
      end
      StRun: begin
        a_d     = a_shr;
        b_d     = b_shr;
        part_d  = part_nxt;
        carry_d = sum[SLICE];
        cnt_d   = cnt_q + CntW'(1);
        if (last) begin
          y_d     = part_nxt;
          co_d    = sum[SLICE];
          ovf_d   = c_msb ^ sum[SLICE];
          zf_d    = (part_nxt == '0);
          done_d  = 1'b1;
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      a_q     <= '0;
      b_q     <= '0;
      sna_q   <= 1'b0;
      carry_q <= 1'b0;
      cnt_q   <= '0;
      part_q  <= '0;
      y_q     <= '0;
      co_q    <= 1'b0;
      ovf_q   <= 1'b0;
      zf_q    <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sna_q   <= sna_d;
      carry_q <= carry_d;
      cnt_q   <= cnt_d;
      part_q  <= part_d;
      y_q     <= y_d;
      co_q    <= co_d;
      ovf_q   <= ovf_d;
      zf_q    <= zf_d;
      done_q  <= done_d;
    end
  end

  assign bus.busy = (state_q == StRun);
  assign bus.done = done_q;
  assign bus.y    = y_q;
  assign bus.co   = co_q;
  assign bus.ovf  = ovf_q;
  assign bus.zf   = zf_q;
endmodule

// File: tb/tb_seq_add_sub.sv
// Scoreboard bench: three slice widths share one stimulus stream; each has its own
// cycle-level reference model and monitor.
module tb_seq_add_sub;
  localparam int unsigned W = 32;

  typedef struct {
    logic [31:0] y;
    logic        co;
    logic        ovf;
    logic        zf;
    int unsigned due;
  } exp_t;

  logic        clk   = 1'b0;
  logic        rst   = 1'b1;
  logic        start = 1'b0;
  logic [31:0] a     = '0;
  logic [31:0] b     = '0;
  logic        sna   = 1'b0;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  function automatic exp_t expect_of(input logic [31:0] ia, input logic [31:0] ib,
                                     input logic isna, input int unsigned due);
    exp_t        e;
    logic [32:0] r;
    if (isna) r = {1'b0, ia} + {1'b0, ~ib} + 33'd1;
    else      r = {1'b0, ia} + {1'b0, ib};
    e.y   = r[31:0];
    e.co  = r[32];
    if (isna) e.ovf = (ia[31] != ib[31]) && (e.y[31] != ia[31]);
    else      e.ovf = (ia[31] == ib[31]) && (e.y[31] != ia[31]);
    e.zf  = (e.y == 32'd0);
    e.due = due;
    return e;
  endfunction

  for (genvar g = 0; g < 3; g++) begin : g_dut
    localparam int unsigned SL = (g == 0) ? 8 : ((g == 1) ? 32 : 1);
    localparam int unsigned NS = W / SL;

    seq_add_sub_if #(.WIDTH(W)) bus ();

    assign bus.start = start;
    assign bus.a     = a;
    assign bus.b     = b;
    assign bus.sna   = sna;

    seq_add_sub #(.WIDTH(W), .SLICE(SL)) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus)
    );

    exp_t        q[$];
    int unsigned edges = 0;
    int unsigned mcnt  = 0;

    // Reference model: an operation occupies NS edges after acceptance; result due NS edges later.
    initial forever begin
      @(posedge clk or posedge rst);
      if (rst) begin
        mcnt = 0;
        q.delete();
      end else begin
        edges++;
        if (mcnt == 0 && start) begin
          q.push_back(expect_of(a, b, sna, edges + NS));
          mcnt = NS;
        end else if (mcnt != 0) begin
          mcnt--;
        end
      end
    end

    initial begin : mon
      exp_t        e;
      logic [31:0] last_y;
      logic        last_co, last_ovf, last_zf;
      last_y = '0; last_co = 1'b0; last_ovf = 1'b0; last_zf = 1'b0;
      forever begin
        @(negedge clk or posedge rst);
        if (rst) begin
          #1;
          n_chk++;
          if (bus.y !== 32'd0 || bus.co !== 1'b0 || bus.ovf !== 1'b0 || bus.zf !== 1'b0 ||
              bus.busy !== 1'b0 || bus.done !== 1'b0) begin
            n_fail++;
            $display("FAIL reset slice=%0d: y=%h co=%b ovf=%b zf=%b busy=%b done=%b, required all 0",
                     SL, bus.y, bus.co, bus.ovf, bus.zf, bus.busy, bus.done);
          end
          last_y = '0; last_co = 1'b0; last_ovf = 1'b0; last_zf = 1'b0;
        end else begin
          n_chk++;
          if (bus.busy !== (mcnt != 0)) begin
            n_fail++;
            $display("FAIL busy slice=%0d edge=%0d: got %b required %b",
                     SL, edges, bus.busy, (mcnt != 0));
          end
          if (bus.done === 1'b1) begin
            n_chk++;
            if (q.size() == 0) begin
              n_fail++;
              $display("FAIL unexpected_done slice=%0d edge=%0d: got done=1 required 0", SL, edges);
            end else begin
              e = q.pop_front();
              if (bus.y !== e.y || bus.co !== e.co || bus.ovf !== e.ovf || bus.zf !== e.zf ||
                  edges != e.due) begin
                n_fail++;
                $display("FAIL result slice=%0d: got y=%h co=%b ovf=%b zf=%b edge=%0d, required y=%h co=%b ovf=%b zf=%b edge=%0d",
                         SL, bus.y, bus.co, bus.ovf, bus.zf, edges, e.y, e.co, e.ovf, e.zf, e.due);
              end
              last_y = e.y; last_co = e.co; last_ovf = e.ovf; last_zf = e.zf;
            end
          end else if (bus.done !== 1'b0) begin
            n_chk++;
            n_fail++;
            $display("FAIL done_level slice=%0d: got %b required 0", SL, bus.done);
          end
          n_chk++;
          if (bus.y !== last_y || bus.co !== last_co || bus.ovf !== last_ovf ||
              bus.zf !== last_zf) begin
            n_fail++;
            $display("FAIL hold slice=%0d edge=%0d: got y=%h co=%b ovf=%b zf=%b, required y=%h co=%b ovf=%b zf=%b",
                     SL, edges, bus.y, bus.co, bus.ovf, bus.zf, last_y, last_co, last_ovf, last_zf);
          end
          while (q.size() > 0 && q[0].due < edges) begin
            n_chk++;
            n_fail++;
            $display("FAIL missing_done slice=%0d: none by edge %0d, required at edge %0d",
                     SL, edges, q[0].due);
            e = q.pop_front();
          end
        end
      end
    end
  end

  task automatic op(input logic [31:0] ia, input logic [31:0] ib, input logic isna,
                    input int unsigned gap);
    @(negedge clk);
    start = 1'b1; a = ia; b = ib; sna = isna;
    @(negedge clk);
    start = 1'b0; a = $urandom; b = $urandom; sna = 1'($urandom_range(0, 1));
    repeat (gap) @(negedge clk);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    rst = 1'b0;

    // Asynchronous reset mid-cycle, outputs checked before any clock edge.
    @(posedge clk);
    #2 rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;

    op(32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 35);
    op(32'h0000_0005, 32'h0000_0007, 1'b1, 35);
    op(32'h8000_0000, 32'h0000_0001, 1'b1, 35);
    op(32'h0000_0000, 32'h0000_0000, 1'b1, 35);

    // START pulses while busy must be ignored.
    @(negedge clk);
    start = 1'b1; a = 32'h7FFF_FFFF; b = 32'h0000_0001; sna = 1'b0;
    @(negedge clk);
    a = 32'h0000_1111; b = 32'h0000_2222; sna = 1'b1;
    @(negedge clk);
    a = 32'hDEAD_BEEF; b = 32'h0BAD_F00D; sna = 1'b0;
    @(negedge clk);
    start = 1'b0;
    repeat (35) @(negedge clk);

    // START held with fresh operands every cycle: back-to-back acceptances.
    start = 1'b1;
    repeat (60) begin
      a = $urandom; b = $urandom; sna = 1'($urandom_range(0, 1));
      @(negedge clk);
    end
    start = 1'b0;
    repeat (35) @(negedge clk);

    // Reset at cycle 2 of an operation aborts it; the next operation runs normally.
    op(32'hAAAA_5555, 32'h1357_9BDF, 1'b0, 0);
    @(posedge clk);
    #2 rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    op(32'h1234_5678, 32'h1111_1111, 1'b0, 35);

    repeat (40) op($urandom, $urandom, 1'($urandom_range(0, 1)), $urandom_range(0, 36));
    op(32'h8000_0000, 32'h8000_0000, 1'b0, 35);
    op(32'h7FFF_FFFF, 32'hFFFF_FFFF, 1'b1, 35);

    repeat (40) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
